led_blink_arbiter: RTL

Round-robin scheduler that shares one board LED among several requesters, each asking for a burst of N blinks. It sits between on-chip status sources and the LED pin, driven from the 48 MHz internal-oscillator clock domain. It serialises requests so blink bursts never overlap, and inserts a dark gap between bursts so they stay visually distinct.

---
 rtl/led_blink_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//
// This module shares one board LED among NUM_REQ status sources. Each source
// asks for a burst of blinks. The bursts are served in round-robin order so
// that two bursts never overlap. A dark gap follows every burst so that
// successive bursts stay visually distinct.
//
// Parameters
//   NUM_REQ   : number of requesters (2..8)
//   TICK_DIV  : clock cycles per LED half-period (>= 2)
//   GAP_TICKS : dark half-periods appended to each burst (>= 1)
//
// Ports
//   clk    in   system clock (48 MHz HF oscillator)
//   reset  in   synchronous, active-high reset
//   req    in   per-requester request level; hold it until done is seen
//   count  in   blink count per requester, nibble i = count[4i+3:4i], 0 = 16
//   grant  out  one-hot active grant, 0 when idle
//   busy   out  high during ON, OFF and GAP
//   done   out  one-cycle pulse when a burst and its gap complete normally
//   led    out  LED drive, active high
//
// All outputs are registered. They are computed from the next state, so they
// change on the same edge as the state register.
module led_blink_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 12_000_000,
  parameter int GAP_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] count,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 done,
  output logic                 led
);

  localparam int GAP_LEN = GAP_TICKS * TICK_DIV;
  localparam int CNT_W   = $clog2(GAP_LEN);
  localparam int PTR_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cyc, cyc_d;
  logic [4:0]         blink_left, blink_left_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]   gnt_idx, gnt_idx_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               done_d;

  logic               req_found;
  logic [PTR_W-1:0]   req_sel;

  // A count nibble of 0 means a full burst of 16 blinks.
  function automatic logic [4:0] burst_len(input logic [3:0] nib);
    return (nib == 4'd0) ? 5'd16 : {1'b0, nib};
  endfunction

  // Round-robin successor. NUM_REQ need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_LAST) ? '0 : idx + PTR_W'(1);
  endfunction

  // Round-robin search. It finds the first set req bit at or above rr_ptr and
  // wraps around modulo NUM_REQ.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    req_found = 1'b0;
    req_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = PTR_W'(idx);
      if (!req_found && req[cand]) begin
        req_found = 1'b1;
        req_sel   = cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state;
    cyc_d        = cyc;
    blink_left_d = blink_left;
    rr_ptr_d     = rr_ptr;
    gnt_idx_d    = gnt_idx;
    grant_d      = grant;
    done_d       = 1'b0;

    case (state)
      S_IDLE: begin
        // The done cycle is a dead cycle. It gives the finishing requester one
        // cycle to drop req before the next arbitration looks at it.
        if (!done && req_found) begin
          state_d      = S_ON;
          gnt_idx_d    = req_sel;
          grant_d      = NUM_REQ'(1) << req_sel;
          blink_left_d = burst_len(count[{req_sel, 2'b00} +: 4]);
          cyc_d        = '0;
        end
      end

      default: begin
        // A withdrawn request takes priority over any phase-end transition.
        if (!req[gnt_idx]) begin
          state_d      = S_IDLE;
          grant_d      = '0;
          cyc_d        = '0;
          blink_left_d = '0;
          rr_ptr_d     = next_ptr(gnt_idx);
        end else begin
          case (state)
            S_ON: begin
              if (cyc == TICK_LAST) begin
                state_d = S_OFF;
                cyc_d   = '0;
              end else begin
                cyc_d = cyc + CNT_W'(1);
              end
            end

            S_OFF: begin
              if (cyc == TICK_LAST) begin
                cyc_d        = '0;
                blink_left_d = blink_left - 5'd1;
                state_d      = (blink_left == 5'd1) ? S_GAP : S_ON;
              end else begin
                cyc_d = cyc + CNT_W'(1);
              end
            end

            S_GAP: begin
              if (cyc == GAP_LAST) begin
                state_d  = S_IDLE;
                cyc_d    = '0;
                grant_d  = '0;
                done_d   = 1'b1;
                rr_ptr_d = next_ptr(gnt_idx);
              end else begin
                cyc_d = cyc + CNT_W'(1);
              end
            end

            default: begin
              state_d = S_IDLE;
              grant_d = '0;
            end
          endcase
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cyc        <= '0;
      blink_left <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      led        <= 1'b0;
    end else begin
      state      <= state_d;
      cyc        <= cyc_d;
      blink_left <= blink_left_d;
      rr_ptr     <= rr_ptr_d;
      gnt_idx    <= gnt_idx_d;
      grant      <= grant_d;
      busy       <= (state_d != S_IDLE);
      done       <= done_d;
      led        <= (state_d == S_ON);
    end
  end

endmodule
